// File: rtl/obi_copy_pkg.sv
// rtl/obi_copy_pkg.sv - shared FSM state type and default sizing for the OBI word-copy master
package obi_copy_pkg;

  localparam int LEN_W_DEFAULT = 12;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    WR_WAIT,
    DONE
  } state_t;

endpackage

// File: rtl/obi_copy_master.sv
// rtl/obi_copy_master.sv - OBI manager that copies len_i aligned 32-bit words from src to dst
module obi_copy_master
  import obi_copy_pkg::*;
#(
  parameter int LEN_W  = LEN_W_DEFAULT,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [LEN_W-1:0]  count_o,
  output logic              req_o,
  input  logic              gnt_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              we_o,
  output logic [3:0]        be_o,
  output logic [31:0]       wdata_o,
  input  logic              rvalid_i,
  input  logic [31:0]       rdata_i,
  input  logic              illegal_i
);

  state_t            state;
  logic [ADDR_W-1:0] src;
  logic [ADDR_W-1:0] dst;
  logic [LEN_W-1:0]  len;
  logic              abort;
  logic [LEN_W-1:0]  cnt_next;
  logic              misaligned;

  assign cnt_next   = count_o + 1'b1;
  assign misaligned = (src_addr_i[1:0] != 2'b00) || (dst_addr_i[1:0] != 2'b00);
  assign busy_o     = (state != IDLE);
  assign done_o     = (state == DONE);

  // Byte address of word idx; wraps silently modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [LEN_W-1:0]  idx);
    return base + (ADDR_W'(idx) << 2);
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      req_o   <= 1'b0;
      we_o    <= 1'b0;
      be_o    <= 4'h0;
      addr_o  <= '0;
      wdata_o <= '0;
      err_o   <= 1'b0;
      count_o <= '0;
      src     <= '0;
      dst     <= '0;
      len     <= '0;
      abort   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            count_o <= '0;
            abort   <= 1'b0;
            if (misaligned) begin
              err_o <= 1'b1;
              state <= DONE;
            end else if (len_i == '0) begin
              err_o <= 1'b0;
              state <= DONE;
            end else begin
              err_o  <= 1'b0;
              src    <= src_addr_i;
              dst    <= dst_addr_i;
              len    <= len_i;
              req_o  <= 1'b1;
              we_o   <= 1'b0;
              be_o   <= 4'hF;
              addr_o <= src_addr_i;
              state  <= RD_REQ;
            end
          end
        end
        RD_REQ, WR_REQ: begin
          if (gnt_i) begin
            req_o <= 1'b0;
            be_o  <= 4'h0;
            // An illegal grant still owes a response; finish it, then stop.
            if (illegal_i) begin
              err_o <= 1'b1;
              abort <= 1'b1;
            end
            state <= (state == RD_REQ) ? RD_WAIT : WR_WAIT;
          end
        end
        RD_WAIT: begin
          if (rvalid_i) begin
            if (abort) begin
              state <= DONE;
            end else begin
              wdata_o <= rdata_i;
              req_o   <= 1'b1;
              we_o    <= 1'b1;
              be_o    <= 4'hF;
              addr_o  <= word_addr(dst, count_o);
              state   <= WR_REQ;
            end
          end
        end
        WR_WAIT: begin
          if (rvalid_i) begin
            we_o <= 1'b0;
            if (abort) begin
              state <= DONE;
            end else begin
              count_o <= cnt_next;
              if (cnt_next == len) begin
                state <= DONE;
              end else begin
                req_o  <= 1'b1;
                be_o   <= 4'hF;
                addr_o <= word_addr(src, cnt_next);
                state  <= RD_REQ;
              end
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obi_copy_master.sv
// tb/tb_obi_copy_master.sv - directed bench for obi_copy_master with a small OBI responder model
module tb_obi_copy_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_a = '0;
  logic [31:0] dst_a = '0;
  logic [11:0] len = '0;
  logic        busy, done, err;
  logic [11:0] count;
  logic        req, gnt, we, rvalid, illegal;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;

  obi_copy_master dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .src_addr_i(src_a), .dst_addr_i(dst_a), .len_i(len),
    .busy_o(busy), .done_o(done), .err_o(err), .count_o(count),
    .req_o(req), .gnt_i(gnt), .addr_o(addr), .we_o(we), .be_o(be),
    .wdata_o(wdata), .rvalid_i(rvalid), .rdata_i(rdata), .illegal_i(illegal)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Responder: grant after gnt_delay waiting cycles, rvalid rv_delay cycles after the first possible one.
  int gnt_delay = 0, rv_delay = 0, illegal_at = 0;
  int wcnt = 0, rwait = 0, rd_grants = 0, wr_grants = 0, req_cyc = 0, stab_err = 0;
  logic        pend = 1'b0, pend_we = 1'b0, hold = 1'b0, h_we = 1'b0;
  logic [31:0] pend_addr = '0, h_addr = '0, h_wdata = '0;
  logic [31:0] src_mem [0:1023];
  logic [31:0] dst_mem [0:1023];

  always_comb begin
    gnt     = req && (wcnt >= gnt_delay);
    rvalid  = pend && (rwait >= rv_delay);
    illegal = gnt && !we && (rd_grants + 1 == illegal_at);
    rdata   = src_mem[pend_addr[11:2]];
  end

  always @(posedge clk) begin
    if (req) req_cyc <= req_cyc + 1;
    wcnt <= (req && !gnt) ? wcnt + 1 : 0;
    if (gnt) begin
      pend      <= 1'b1;
      rwait     <= 0;
      pend_addr <= addr;
      pend_we   <= we;
      if (we) begin
        wr_grants <= wr_grants + 1;
        dst_mem[addr[11:2]] <= wdata;
      end else begin
        rd_grants <= rd_grants + 1;
      end
    end else if (rvalid) begin
      pend <= 1'b0;
    end else if (pend) begin
      rwait <= rwait + 1;
    end
    hold    <= req && !gnt;
    h_addr  <= addr;
    h_wdata <= wdata;
    h_we    <= we;
    if (hold && (!req || addr != h_addr || wdata != h_wdata || we != h_we))
      stab_err <= stab_err + 1;
  end

  task automatic run_start(input logic [31:0] s, input logic [31:0] d, input logic [11:0] n);
    @(negedge clk);
    src_a = s; dst_a = d; len = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns the cycle index after the start edge at which done_o is seen, or -1 on timeout.
  task automatic wait_done(output int j);
    j = 1;
    while (!done && j < 200) begin
      @(negedge clk);
      j++;
    end
    if (!done) j = -1;
  endtask

  int j, rd0, wr0, rq0;

  task automatic snap();
    rd0 = rd_grants; wr0 = wr_grants; rq0 = req_cyc;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) src_mem[i] = (32'(i) * 32'h9E3779B1) ^ 32'h5A5A_0000;

    #2 rst = 1'b1;
    #1;
    chk("rst_req", req, 0);   chk("rst_we", we, 0);       chk("rst_be", be, 0);
    chk("rst_addr", addr, 0); chk("rst_wdata", wdata, 0); chk("rst_busy", busy, 0);
    chk("rst_done", done, 0); chk("rst_err", err, 0);     chk("rst_count", count, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Zero-wait copy of 4 words
    snap();
    run_start(32'h8000_0000, 32'h8000_0800, 12'd4);
    wait_done(j);
    chk("t1_done_cycle", j, 17);
    chk("t1_count", count, 4);
    chk("t1_err", err, 0);
    chk("t1_reads", rd_grants - rd0, 4);
    chk("t1_writes", wr_grants - wr0, 4);
    for (int w = 0; w < 4; w++) chk("t1_data", dst_mem[512 + w], src_mem[w]);
    @(negedge clk);
    chk("t1_idle_busy", busy, 0);

    // Slow grants and responses
    gnt_delay = 3; rv_delay = 2;
    run_start(32'h8000_0040, 32'h8000_0900, 12'd2);
    wait_done(j);
    chk("t2_done_cycle", j, 29);
    chk("t2_count", count, 2);
    chk("t2_stable", stab_err, 0);
    for (int w = 0; w < 2; w++) chk("t2_data", dst_mem[576 + w], src_mem[16 + w]);
    @(negedge clk);
    gnt_delay = 0; rv_delay = 0;

    // Zero length
    snap();
    run_start(32'h8000_0000, 32'h8000_0800, 12'd0);
    wait_done(j);
    chk("t3_done_cycle", j, 1);
    chk("t3_err", err, 0);
    chk("t3_count", count, 0);
    @(negedge clk);
    chk("t3_no_req", req_cyc - rq0, 0);

    // Misaligned destination
    snap();
    run_start(32'h8000_0000, 32'h8000_0002, 12'd3);
    wait_done(j);
    chk("t4_done_cycle", j, 1);
    chk("t4_err", err, 1);
    @(negedge clk);
    chk("t4_no_req", req_cyc - rq0, 0);
    chk("t4_err_sticky", err, 1);

    // Illegal on the second read grant
    snap();
    illegal_at = rd_grants + 2;
    run_start(32'h8000_0080, 32'h8000_0A00, 12'd5);
    chk("t5_err_cleared", err, 0);
    wait_done(j);
    chk("t5_done_cycle", j, 7);
    chk("t5_err", err, 1);
    chk("t5_count", count, 1);
    chk("t5_reads", rd_grants - rd0, 2);
    chk("t5_writes", wr_grants - wr0, 1);
    chk("t5_data", dst_mem[640], src_mem[32]);
    repeat (3) @(negedge clk);
    chk("t5_no_more_req", req_cyc - rq0, 3);
    illegal_at = 0;

    // Reset during write-wait of the third word, then a normal one-word copy
    run_start(32'h8000_00C0, 32'h8000_0B00, 12'd5);
    j = 1;
    while (j < 12) begin
      @(negedge clk);
      j++;
    end
    chk("t6_busy_before", busy, 1);
    chk("t6_count_before", count, 2);
    rst = 1'b1;
    #1;
    chk("t6_req", req, 0);
    chk("t6_busy", busy, 0);
    chk("t6_count", count, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_idle_after", busy, 0);

    snap();
    run_start(32'h8000_00F0, 32'h8000_0BE0, 12'd1);
    wait_done(j);
    chk("t7_done_cycle", j, 5);
    chk("t7_count", count, 1);
    chk("t7_err", err, 0);
    chk("t7_data", dst_mem[760], src_mem[60]);
    chk("t7_reads", rd_grants - rd0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/obi_copy_master.md
OBI_COPY_MASTER -- requirements
Module: obi_copy_master

Interface
REQ-001 SHALL have parameter LEN_W, default 12, giving the width of the word-count and progress fields.
REQ-002 SHALL have parameter ADDR_W, default 32, giving the OBI address width.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start_i  input  1  one-cycle copy request; sampled only in IDLE.
REQ-006 SHALL have port src_addr_i  input  ADDR_W  source byte address of word 0.
REQ-007 SHALL have port dst_addr_i  input  ADDR_W  destination byte address of word 0.
REQ-008 SHALL have port len_i  input  LEN_W  number of 32-bit words to copy.
REQ-009 SHALL have port busy_o  output  1  high while not in IDLE.
REQ-010 SHALL have port done_o  output  1  one-cycle completion pulse.
REQ-011 SHALL have port err_o  output  1  sticky error flag, cleared on the next accepted start.
REQ-012 SHALL have port count_o  output  LEN_W  number of words fully written in the current or last copy.
REQ-013 SHALL have OBI manager ports: req_o out 1, gnt_i in 1, addr_o out ADDR_W, we_o out 1, be_o out 4, wdata_o out 32, rvalid_i in 1, rdata_i in 32.
REQ-014 SHALL have port illegal_i  input  1  responder illegal-access flag, valid in any cycle where req_o and gnt_i are both high.

Function
REQ-015 SHALL implement FSM states IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE.
REQ-016 On start_i in IDLE with len_i==0, SHALL go to DONE with no OBI traffic.
REQ-017 On start_i in IDLE with src_addr_i[1:0]!=0 or dst_addr_i[1:0]!=0, SHALL set err_o, go to DONE, and issue no OBI traffic.
REQ-018 On any other start_i in IDLE, SHALL latch the addresses and length, clear count_o and err_o, and go to RD_REQ.
REQ-019 In RD_REQ: req_o=1, we_o=0, be_o=4'hF, addr_o=src+4*count_o; advance to RD_WAIT on gnt_i.
REQ-020 In WR_REQ: req_o=1, we_o=1, be_o=4'hF, addr_o=dst+4*count_o, wdata_o=captured read word; advance to WR_WAIT on gnt_i.
REQ-021 Address, we, be and wdata SHALL stay stable while req_o=1 and gnt_i=0; req_o SHALL never drop before grant.
REQ-022 req_o SHALL be low in RD_WAIT, WR_WAIT, IDLE and DONE; at most one transaction is outstanding at a time.
REQ-023 In RD_WAIT, on rvalid_i, SHALL capture rdata_i into the data register and go to WR_REQ.
REQ-024 In WR_WAIT, on rvalid_i, SHALL increment count_o; go to DONE if the new count equals the latched length, else go to RD_REQ.
REQ-025 illegal_i high at a grant SHALL set err_o; the FSM still waits for that transaction's rvalid_i, then goes to DONE with no further requests.
REQ-026 DONE SHALL last exactly one cycle with done_o=1, then return to IDLE.
REQ-027 start_i outside IDLE SHALL be ignored.
REQ-028 Address arithmetic SHALL be modulo 2^ADDR_W; wrap-around past the top of the address space is not an error.
REQ-029 With a zero-wait responder (gnt same cycle, rvalid next cycle), start sampled at edge k SHALL give done_o in cycle k+4N+1 for N words.

Reset
REQ-030 rst_i SHALL asynchronously force IDLE, req_o=0, we_o=0, be_o=0, addr_o=0, wdata_o=0, busy_o=0, done_o=0, err_o=0, count_o=0.
REQ-031 Reset mid-copy SHALL abandon the transfer; any late rvalid_i arriving in IDLE SHALL be ignored.

Structure
REQ-032 The state enum and the default LEN_W SHALL live in package obi_copy_pkg.
REQ-033 The block SHALL be a single module with no sub-modules; all outputs except done_o and busy_o SHALL be registered.

Verification
REQ-034 src=0x8000_0000, dst=0x8000_0800, len=4, zero-wait responder -> 4 reads then 4 writes interleaved, destination words equal source, done_o in cycle k+17, count_o=4.
REQ-035 gnt_i held low 3 cycles on each request -> req_o, addr_o and wdata_o stable throughout, data correct, done_o at k+29 for len=2.
REQ-036 len=0 -> done_o at k+1, req_o never high, err_o=0.
REQ-037 dst=0x8000_0002 -> err_o=1, done_o at k+1, no requests issued.
REQ-038 illegal_i=1 on the 2nd read grant, len=5 -> err_o=1, count_o=1, done_o one cycle after that rvalid, no further req_o.
REQ-039 rst_i asserted during WR_WAIT of word 3 -> req_o=0 immediately, busy_o=0, count_o=0; a following start with len=1 completes normally.
